rob_buffer: RTL and testbench

ROB_BUFFER -- requirements
Module: rob_buffer

---
 rtl/rob_buffer_pkg.sv | 51 +++++
 rtl/rob_buffer_ptr_ctrl.sv | 63 ++++++
 rtl/rob_buffer.sv | 159 +++++++++++++++
 tb/tb_rob_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_buffer_pkg.sv
// -----------------------------------------------------------------------------
// rob_buffer_pkg
// Shared utility types for the reorder buffer and the write-back network:
//   rob_rf_data   - one ROB entry (status bits plus speculative payload)
//   cdb_bfm       - one common-data-bus write-back beat
//   ROB_RET_LANES - number of retire lanes exposed by the ROB
// -----------------------------------------------------------------------------
package rob_buffer_pkg;

    localparam int XLEN          = 32;
    localparam int AREG_W        = 5;
    // CDB tags are carried at a fixed width so the bus type is shared by
    // every ROB size up to 256 entries; out-of-range tags never hit.
    localparam int CDB_TAG_W     = 8;
    localparam int ROB_RET_LANES = 2;

    typedef struct packed {
        logic              valid;
        logic              spec_valid;
        logic              is_branch;
        logic              branch_taken;
        logic [AREG_W-1:0] dest;
        logic [XLEN-1:0]   spec_data;
        logic [XLEN-1:0]   store_data;
    } rob_rf_data;

    typedef struct packed {
        logic                 cdb_valid;
        logic [CDB_TAG_W-1:0] cdb_tag;
        logic [XLEN-1:0]      cdb_result;
        logic [XLEN-1:0]      store_data;
        logic                 cdb_branch_taken;
    } cdb_bfm;

    // A taken branch must retire alone so the front end can redirect.
    function automatic logic is_taken_branch(input rob_rf_data e);
        return e.is_branch & e.branch_taken;
    endfunction

    // Overlay a CDB beat onto an entry: result fields plus spec_valid.
    function automatic rob_rf_data merge_cdb(input rob_rf_data e, input cdb_bfm c);
        rob_rf_data m;
        m              = e;
        m.spec_data    = c.cdb_result;
        m.store_data   = c.store_data;
        m.branch_taken = c.cdb_branch_taken;
        m.spec_valid   = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rob_buffer_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// rob_ptr_ctrl
// Head/tail/count bookkeeping for the reorder buffer.
//   clk, i_rst_n  - clock, asynchronous active-low reset
//   alloc_valid   - allocation request (accepted only when not full)
//   retire_num    - number of entries retired this cycle (0..2)
//   flush         - synchronous squash, overrides alloc and retire
//   head, tail    - oldest entry / next free entry
//   count         - occupied entries; full/empty derive from it
//   alloc_ready   - not full;  alloc_fire - allocation accepted this cycle
// -----------------------------------------------------------------------------
module rob_ptr_ctrl
    import rob_buffer_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             alloc_valid,
    input  logic [1:0]       retire_num,
    input  logic             flush,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             alloc_ready,
    output logic             alloc_fire
);

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    // Full blocks allocation even when a retire frees a slot this cycle.
    assign full        = (count_r == CNT_W'(DEPTH));
    assign empty       = (count_r == CNT_W'(0));
    assign alloc_ready = ~full;
    assign alloc_fire  = alloc_valid & ~full;
    assign head        = head_r;
    assign tail        = tail_r;
    assign count       = count_r;

    // Pointer and occupancy update; pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_r  <= TAG_W'(0);
            tail_r  <= TAG_W'(0);
            count_r <= CNT_W'(0);
        end else if (flush) begin
            head_r  <= TAG_W'(0);
            tail_r  <= TAG_W'(0);
            count_r <= CNT_W'(0);
        end else begin
            head_r  <= head_r + TAG_W'(retire_num);
            tail_r  <= tail_r + TAG_W'(alloc_fire);
            count_r <= count_r + CNT_W'(alloc_fire) - CNT_W'(retire_num);
        end
    end

endmodule

// File: rtl/rob_buffer.sv
// -----------------------------------------------------------------------------
// rob_buffer
// Reorder buffer: in-order allocate at tail, out-of-order CDB write-back,
// bypassed speculative reads, in-order retirement of up to RET_W entries.
//   alloc_valid/alloc_data/alloc_ready/alloc_tag - allocation handshake
//   rs1_tag/rs2_tag -> rs1_data/rs2_data          - reads with CDB bypass
//   cdb[N_CDB]                                    - write-back buses
//   retire_ready/retire_valid/retire_data         - commit interface
//   flush                                         - squash all entries
//   count/full/empty                              - occupancy status
// -----------------------------------------------------------------------------
module rob_buffer
    import rob_buffer_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int N_CDB = 2,
    parameter  int RET_W = ROB_RET_LANES,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             alloc_valid,
    input  rob_rf_data       alloc_data,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] rs1_tag,
    input  logic [TAG_W-1:0] rs2_tag,
    output rob_rf_data       rs1_data,
    output rob_rf_data       rs2_data,
    input  cdb_bfm           cdb [N_CDB],
    input  logic             retire_ready,
    output logic [RET_W-1:0] retire_valid,
    output rob_rf_data       retire_data [RET_W],
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // Payload is never reset; status bits live in separate vectors.
    rob_rf_data       payload_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] spec_valid_r;

    logic [TAG_W-1:0] head_s;
    logic [TAG_W-1:0] tail_s;
    logic             alloc_fire_s;
    logic [1:0]       retire_num_s;

    logic [N_CDB-1:0] cdb_hit_s;
    logic [TAG_W-1:0] cdb_tag_s  [N_CDB];
    logic [TAG_W-1:0] lane_tag_s [RET_W];
    rob_rf_data       lane_s     [RET_W];
    logic [RET_W-1:0] retire_valid_s;
    logic             lane_ok_s;

    rob_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .alloc_valid (alloc_valid),
        .retire_num  (retire_num_s),
        .flush       (flush),
        .head        (head_s),
        .tail        (tail_s),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .alloc_ready (alloc_ready),
        .alloc_fire  (alloc_fire_s)
    );

    assign alloc_tag = tail_s;

    // CDB decode: a beat hits only an in-range tag whose entry is valid.
    always_comb begin
        for (int k = 0; k < N_CDB; k++) begin
            cdb_tag_s[k] = cdb[k].cdb_tag[TAG_W-1:0];
            cdb_hit_s[k] = cdb[k].cdb_valid
                         & ((cdb[k].cdb_tag >> TAG_W) == CDB_TAG_W'(0))
                         & valid_r[cdb_tag_s[k]];
        end
    end

    // Speculative reads; later CDB ports override earlier ones.
    always_comb begin
        rs1_data            = payload_r[rs1_tag];
        rs1_data.valid      = valid_r[rs1_tag];
        rs1_data.spec_valid = spec_valid_r[rs1_tag];
        rs2_data            = payload_r[rs2_tag];
        rs2_data.valid      = valid_r[rs2_tag];
        rs2_data.spec_valid = spec_valid_r[rs2_tag];
        for (int k = 0; k < N_CDB; k++) begin
            rs1_data = (cdb_hit_s[k] && (cdb_tag_s[k] == rs1_tag)) ? merge_cdb(rs1_data, cdb[k]) : rs1_data;
            rs2_data = (cdb_hit_s[k] && (cdb_tag_s[k] == rs2_tag)) ? merge_cdb(rs2_data, cdb[k]) : rs2_data;
        end
    end

    // Retire lanes from registered state only; a lane needs all older
    // lanes retireable and no taken branch ahead of it.
    always_comb begin
        lane_ok_s      = 1'b1;
        retire_num_s   = 2'd0;
        retire_valid_s = RET_W'(0);
        for (int i = 0; i < RET_W; i++) begin
            lane_tag_s[i]        = head_s + TAG_W'(i);
            lane_s[i]            = payload_r[lane_tag_s[i]];
            lane_s[i].valid      = valid_r[lane_tag_s[i]];
            lane_s[i].spec_valid = spec_valid_r[lane_tag_s[i]];
            retire_valid_s[i]    = lane_ok_s & lane_s[i].valid & lane_s[i].spec_valid;
            lane_ok_s            = retire_valid_s[i] & ~is_taken_branch(lane_s[i]);
            retire_num_s         = retire_num_s + {1'b0, retire_valid_s[i] & retire_ready};
            retire_data[i]       = retire_valid_s[i] ? lane_s[i] : rob_rf_data'(0);
        end
        retire_valid = retire_valid_s;
    end

    // Entry payload: allocate at tail, then CDB results in port order.
    always_ff @(posedge clk) begin
        if (alloc_fire_s && !flush) begin
            payload_r[tail_s] <= alloc_data;
        end
        for (int k = 0; k < N_CDB; k++) begin
            if (cdb_hit_s[k] && !flush) begin
                payload_r[cdb_tag_s[k]].spec_data    <= cdb[k].cdb_result;
                payload_r[cdb_tag_s[k]].store_data   <= cdb[k].store_data;
                payload_r[cdb_tag_s[k]].branch_taken <= cdb[k].cdb_branch_taken;
            end
        end
    end

    // Status bits: flush wins; retire clears after CDB sets.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r      <= DEPTH'(0);
            spec_valid_r <= DEPTH'(0);
        end else if (flush) begin
            valid_r      <= DEPTH'(0);
            spec_valid_r <= DEPTH'(0);
        end else begin
            if (alloc_fire_s) begin
                valid_r[tail_s]      <= 1'b1;
                spec_valid_r[tail_s] <= 1'b0;
            end
            for (int k = 0; k < N_CDB; k++) begin
                if (cdb_hit_s[k]) begin
                    spec_valid_r[cdb_tag_s[k]] <= 1'b1;
                end
            end
            for (int i = 0; i < RET_W; i++) begin
                if (retire_valid_s[i] && retire_ready) begin
                    valid_r[lane_tag_s[i]]      <= 1'b0;
                    spec_valid_r[lane_tag_s[i]] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_buffer.sv
// -----------------------------------------------------------------------------
// tb_rob_buffer
// Directed stimulus for rob_buffer with a reference model of the ROB: each
// allocation pushes its tag into an in-order queue, CDB beats update the
// model entries, and retirements pop and compare against the DUT lanes.
// -----------------------------------------------------------------------------
module tb_rob_buffer;
    import rob_buffer_pkg::*;

    localparam int DEPTH = 64;
    localparam int N_CDB = 2;
    localparam int RET_W = 2;
    localparam int TAG_W = 6;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             alloc_valid;
    rob_rf_data       alloc_data;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    rob_rf_data       rs1_data;
    rob_rf_data       rs2_data;
    cdb_bfm           cdb [N_CDB];
    logic             retire_ready;
    logic [RET_W-1:0] retire_valid;
    rob_rf_data       retire_data [RET_W];
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // reference model
    logic       m_valid [DEPTH];
    logic       m_ready [DEPTH];
    rob_rf_data m_ent   [DEPTH];
    int         m_tail;
    int         m_count;
    int         q [$];

    always #5 clk = ~clk;

    rob_buffer #(.DEPTH(DEPTH), .N_CDB(N_CDB), .RET_W(RET_W)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .alloc_valid  (alloc_valid),
        .alloc_data   (alloc_data),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .cdb          (cdb),
        .retire_ready (retire_ready),
        .retire_valid (retire_valid),
        .retire_data  (retire_data),
        .flush        (flush),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rob_rf_data mk(input int d, input logic br);
        rob_rf_data e;
        e              = rob_rf_data'(0);
        e.dest         = 5'(d);
        e.is_branch    = br;
        e.spec_data    = 32'hDEAD_0000 | 32'(d);
        e.store_data   = 32'h0000_0000;
        e.branch_taken = 1'b0;
        return e;
    endfunction

    function automatic cdb_bfm mkcdb(input int tag, input logic [31:0] res, input logic taken);
        cdb_bfm c;
        c.cdb_valid        = 1'b1;
        c.cdb_tag          = 8'(tag);
        c.cdb_result       = res;
        c.store_data       = res ^ 32'hFFFF_0000;
        c.cdb_branch_taken = taken;
        return c;
    endfunction

    task automatic clear_inputs();
        alloc_valid  = 1'b0;
        alloc_data   = rob_rf_data'(0);
        retire_ready = 1'b0;
        flush        = 1'b0;
        for (int k = 0; k < N_CDB; k++) cdb[k] = cdb_bfm'(0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ready[i] = 1'b0;
        end
        q.delete();
        m_tail  = 0;
        m_count = 0;
    endtask

    // Check outputs against the model, advance the model, then clock once.
    task automatic cycle();
        logic [1:0] erv;
        int         n;
        int         t;
        logic       fire;
        rob_rf_data e;
        #1;
        erv = 2'b00;
        if (q.size() > 0 && m_ready[q[0]]) erv[0] = 1'b1;
        if (erv[0] && q.size() > 1 && m_ready[q[1]] &&
            !(m_ent[q[0]].is_branch && m_ent[q[0]].branch_taken)) erv[1] = 1'b1;
        chk("retire_valid", retire_valid, erv);
        for (int i = 0; i < RET_W; i++) begin
            if (erv[i]) chk("retire_data", retire_data[i], m_ent[q[i]]);
            else        chk("retire_zero", retire_data[i], 128'd0);
        end
        chk("count", count, m_count);
        chk("full", full, (m_count == DEPTH));
        chk("empty", empty, (m_count == 0));
        chk("alloc_tag", alloc_tag, m_tail);
        chk("alloc_ready", alloc_ready, (m_count < DEPTH));

        fire = alloc_valid && (m_count < DEPTH);
        if (flush) begin
            model_reset();
        end else begin
            for (int k = 0; k < N_CDB; k++) begin
                t = int'(cdb[k].cdb_tag);
                if (cdb[k].cdb_valid && t < DEPTH && m_valid[t]) begin
                    m_ent[t].spec_data    = cdb[k].cdb_result;
                    m_ent[t].store_data   = cdb[k].store_data;
                    m_ent[t].branch_taken = cdb[k].cdb_branch_taken;
                    m_ent[t].spec_valid   = 1'b1;
                    m_ready[t]            = 1'b1;
                end
            end
            n = 0;
            if (retire_ready) n = int'(erv[0]) + int'(erv[1]);
            for (int i = 0; i < n; i++) begin
                t = q.pop_front();
                m_valid[t] = 1'b0;
                m_ready[t] = 1'b0;
            end
            if (fire) begin
                e            = alloc_data;
                e.valid      = 1'b1;
                e.spec_valid = 1'b0;
                m_ent[m_tail]   = e;
                m_valid[m_tail] = 1'b1;
                m_ready[m_tail] = 1'b0;
                q.push_back(m_tail);
                m_tail = (m_tail + 1) % DEPTH;
            end
            m_count = m_count + int'(fire) - n;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0;
        rs1_tag = 6'd0;
        rs2_tag = 6'd0;
        clear_inputs();
        model_reset();
        #12;
        chk("rst_count", count, 128'd0);
        chk("rst_alloc_ready", alloc_ready, 128'd1);
        chk("rst_alloc_tag", alloc_tag, 128'd0);
        chk("rst_empty", empty, 128'd1);
        chk("rst_full", full, 128'd0);
        chk("rst_retire_valid", retire_valid, 128'd0);
        chk("rst_retire_data0", retire_data[0], 128'd0);
        chk("rst_retire_data1", retire_data[1], 128'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three allocations: tags 0,1,2
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_data  = mk(10 + i, 1'b0);
            cycle();
        end
        clear_inputs();
        cycle();
        chk("count_after_3", count, 128'd3);

        // tag 1 completes while tag 0 pending: bypass visible, no retire
        cdb[0]  = mkcdb(1, 32'h55, 1'b0);
        rs1_tag = 6'd1;
        #1;
        chk("bypass_rs1_data", rs1_data.spec_data, 128'h55);
        chk("bypass_rs1_sv", rs1_data.spec_valid, 128'd1);
        cycle();
        clear_inputs();
        cycle();
        cdb[1] = mkcdb(0, 32'h44, 1'b0);
        cycle();
        clear_inputs();
        retire_ready = 1'b1;
        cycle();
        clear_inputs();
        // head is now 2: completing tag 2 makes lane 0 carry it
        cdb[0] = mkcdb(2, 32'h66, 1'b0);
        cycle();
        clear_inputs();
        retire_ready = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        // tags 3..7, tag 3 is a branch
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1;
            alloc_data  = mk(20 + i, (i == 0));
            cycle();
        end
        clear_inputs();
        // both CDB ports hit tag 5: port 1 wins
        cdb[0]  = mkcdb(5, 32'hA, 1'b0);
        cdb[1]  = mkcdb(5, 32'hB, 1'b0);
        rs1_tag = 6'd5;
        #1;
        chk("dual_cdb_bypass", rs1_data.spec_data, 128'hB);
        cycle();
        clear_inputs();
        rs2_tag = 6'd5;
        #1;
        chk("dual_cdb_stored", rs2_data.spec_data, 128'hB);
        chk("dual_cdb_stored_sv", rs2_data.spec_valid, 128'd1);

        // taken branch at head retires alone
        cdb[0] = mkcdb(3, 32'h33, 1'b1);
        cdb[1] = mkcdb(4, 32'h44, 1'b0);
        cycle();
        clear_inputs();
        retire_ready = 1'b1;
        cycle();
        cycle();
        clear_inputs();
        cycle();

        // flush together with alloc, CDB and retire
        cdb[0] = mkcdb(6, 32'h66, 1'b0);
        cycle();
        clear_inputs();
        alloc_valid  = 1'b1;
        alloc_data   = mk(1, 1'b0);
        cdb[0]       = mkcdb(7, 32'h77, 1'b0);
        retire_ready = 1'b1;
        flush        = 1'b1;
        cycle();
        clear_inputs();
        chk("flush_count", count, 128'd0);
        chk("flush_empty", empty, 128'd1);
        chk("flush_tag", alloc_tag, 128'd0);
        chk("flush_retire_valid", retire_valid, 128'd0);

        // fill to DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            alloc_data  = mk(i, 1'b0);
            cycle();
        end
        clear_inputs();
        chk("fill_full", full, 128'd1);
        chk("fill_alloc_ready", alloc_ready, 128'd0);
        alloc_valid = 1'b1;
        alloc_data  = mk(30, 1'b0);
        cycle();
        clear_inputs();
        chk("overflow_count", count, 128'd64);
        cdb[0] = mkcdb(0, 32'h1234, 1'b0);
        cycle();
        clear_inputs();
        // full: allocate rejected though a retire happens
        alloc_valid  = 1'b1;
        alloc_data   = mk(31, 1'b0);
        retire_ready = 1'b1;
        cycle();
        clear_inputs();
        chk("retire_one_count", count, 128'd63);
        chk("wrap_tag", alloc_tag, 128'd0);
        alloc_valid = 1'b1;
        alloc_data  = mk(2, 1'b0);
        cycle();
        clear_inputs();
        cycle();

        // reset mid-operation with a retireable head
        cdb[1] = mkcdb(1, 32'h99, 1'b0);
        cycle();
        clear_inputs();
        #1;
        chk("pre_rst_retire_valid", retire_valid, 128'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_retire_valid", retire_valid, 128'd0);
        chk("midrst_retire_data", retire_data[0], 128'd0);
        chk("midrst_count", count, 128'd0);
        chk("midrst_empty", empty, 128'd1);
        model_reset();
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        alloc_valid = 1'b1;
        alloc_data  = mk(5, 1'b0);
        cycle();
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
